// File: rtl/regfile_mp.sv
// Multi-port integer register file: n_rd combinational read ports, two write ports,
// optional write-to-read bypass, hardwired x0 and a per-register busy scoreboard.
module regfile_mp #(
   parameter int d_width  = 32,
   parameter int a_width  = 5,
   parameter int n_rd     = 3,
   parameter int bypass   = 1,
   parameter int zero_reg = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [n_rd*a_width-1:0]   raddr,
   output logic [n_rd*d_width-1:0]   rdata,
   output logic [n_rd-1:0]           rvalid,
   input  logic                      wen0,
   input  logic [a_width-1:0]        waddr0,
   input  logic [d_width-1:0]        wdata0,
   input  logic                      wen1,
   input  logic [a_width-1:0]        waddr1,
   input  logic [d_width-1:0]        wdata1,
   input  logic                      set_en,
   input  logic [a_width-1:0]        set_addr,
   output logic                      busy_any
);

   localparam int depth = 2 ** a_width;

   logic [d_width-1:0] regs_q [depth];
   logic [d_width-1:0] regs_d [depth];
   logic [depth-1:0]   busy_q;
   logic [depth-1:0]   busy_d;

   logic w0_act;
   logic w1_act;
   logic set_act;

   // Writes are qualified by rst_n so nothing is forwarded while reset is held.
   always_comb begin
      w0_act  = wen0 & rst_n;
      w1_act  = wen1 & rst_n;
      set_act = set_en & rst_n;
      if (zero_reg != 0) begin
         if (waddr0 == '0)   w0_act  = 1'b0;
         if (waddr1 == '0)   w1_act  = 1'b0;
         if (set_addr == '0) set_act = 1'b0;
      end
   end

   // Port 1 is applied after port 0 so it wins an address collision;
   // the set is applied last so a newly issued producer keeps the register busy.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      if (w0_act) begin
         regs_d[waddr0] = wdata0;
         busy_d[waddr0] = 1'b0;
      end
      if (w1_act) begin
         regs_d[waddr1] = wdata1;
         busy_d[waddr1] = 1'b0;
      end
      if (set_act) busy_d[set_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < depth; i++) regs_q[i] <= '0;
         busy_q <= '0;
      end else begin
         for (int i = 0; i < depth; i++) regs_q[i] <= regs_d[i];
         busy_q <= busy_d;
      end
   end

   assign busy_any = |busy_q;

   genvar gi;
   generate
      for (gi = 0; gi < n_rd; gi++) begin : g_rd
         logic [a_width-1:0] ra;
         logic [d_width-1:0] rd_data;
         logic               rd_valid;

         assign ra = raddr[gi*a_width +: a_width];

         always_comb begin
            rd_data  = regs_q[ra];
            rd_valid = ~busy_q[ra];
            if (bypass != 0) begin
               if (w0_act && (waddr0 == ra)) begin
                  rd_data  = wdata0;
                  rd_valid = 1'b1;
               end
               if (w1_act && (waddr1 == ra)) begin
                  rd_data  = wdata1;
                  rd_valid = 1'b1;
               end
            end
            if ((zero_reg != 0) && (ra == '0)) begin
               rd_data  = '0;
               rd_valid = 1'b1;
            end
         end

         assign rdata[gi*d_width +: d_width] = rd_data;
         assign rvalid[gi]                   = rd_valid;
      end
   endgenerate

endmodule
